// File: rtl/data_mem_if.sv
// Request/response bundle between the ALU-facing upstream and the data memory stage.
// Upstream drives the request fields; the stage returns the registered load result and flags.
interface data_mem_if #(
    parameter int DATAWIDTH = 32
);
    logic [DATAWIDTH-1:0] Addr_i;
    logic [DATAWIDTH-1:0] WriteData_i;
    logic                 MemRead_i;
    logic                 MemWrite_i;
    logic [2:0]           SizeCtrl_i;
    logic                 Stall_i;
    logic [DATAWIDTH-1:0] ReadData_o;
    logic                 LoadValid_o;
    logic                 Misaligned_o;

    modport master (
        output Addr_i, WriteData_i, MemRead_i, MemWrite_i, SizeCtrl_i, Stall_i,
        input  ReadData_o, LoadValid_o, Misaligned_o
    );

    modport slave (
        input  Addr_i, WriteData_i, MemRead_i, MemWrite_i, SizeCtrl_i, Stall_i,
        output ReadData_o, LoadValid_o, Misaligned_o
    );
endinterface

// File: rtl/data_mem_stage.sv
// RV32I load/store stage on an internal little-endian word RAM, byte-lane writes, sign/zero-extended reads.
// Latency: load result, valid and misalignment flags are registered one cycle after the request.
// Backpressure: Stall_i freezes the stage (no write, outputs held); upstream re-presents the request.
module data_mem_stage #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [DATAWIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic [2:0]            size;
    logic                  is_wr, is_rd, misal, size_bad, req_bad;
    logic                  do_store, do_load;
    logic [3:0]            be;
    logic [DATAWIDTH-1:0]  wdat, rd_word, rd_shift, ld_ext;
    logic                  unused_addr_hi;

    assign word_idx       = bus.Addr_i[ADDR_WIDTH-1:2];
    assign lane           = bus.Addr_i[1:0];
    assign size           = bus.SizeCtrl_i;
    assign unused_addr_hi = ^bus.Addr_i[DATAWIDTH-1:ADDR_WIDTH];

    // A store with the read strobe also set is still just a store.
    always_comb begin
        is_wr = bus.MemWrite_i;
        is_rd = bus.MemRead_i & ~bus.MemWrite_i;
        misal = ((size[1:0] == 2'b01) & lane[0]) |
                ((size[1:0] == 2'b10) & (lane != 2'b00));
        if (is_wr) size_bad = size[2] | (size[1:0] == 2'b11);
        else       size_bad = (size == 3'b011) | (size == 3'b110) | (size == 3'b111);
        req_bad  = (is_wr | is_rd) & (size_bad | misal);
        do_store = is_wr & ~req_bad & ~bus.Stall_i;
        do_load  = is_rd & ~req_bad & ~bus.Stall_i;
    end

    always_comb begin
        case (size[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        case (size[1:0])
            2'b00:   wdat = {4{bus.WriteData_i[7:0]}};
            2'b01:   wdat = {2{bus.WriteData_i[15:0]}};
            default: wdat = bus.WriteData_i;
        endcase
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (size)
            3'b000:  ld_ext = {{(DATAWIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{(DATAWIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {{(DATAWIDTH-8){1'b0}}, rd_shift[7:0]};
            3'b101:  ld_ext = {{(DATAWIDTH-16){1'b0}}, rd_shift[15:0]};
            default: ld_ext = rd_word;
        endcase
    end

    // RAM contents survive reset; the write simply cannot fire while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ReadData_o   <= '0;
            bus.LoadValid_o  <= 1'b0;
            bus.Misaligned_o <= 1'b0;
        end else if (!bus.Stall_i) begin
            if (req_bad) begin
                bus.ReadData_o   <= '0;
                bus.LoadValid_o  <= 1'b0;
                bus.Misaligned_o <= 1'b1;
            end else if (do_load) begin
                bus.ReadData_o   <= ld_ext;
                bus.LoadValid_o  <= 1'b1;
                bus.Misaligned_o <= 1'b0;
            end else begin
                bus.LoadValid_o  <= 1'b0;
                bus.Misaligned_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed table, reset corner cases, randomized traffic vs. a byte-array model.
module tb_data_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    data_mem_if #(.DATAWIDTH(32)) bus ();

    data_mem_stage #(.DATAWIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed memory plus the expected registered outputs.
    logic [7:0]  mem_b [4096];
    logic [31:0] m_dat;
    logic        m_vld, m_mis;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  sz;
        logic [31:0] ad, wd;
        logic        st;
        logic [31:0] edat;
        logic        evld, emis, chkd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] sz, logic [31:0] ad, logic [31:0] wd,
                                logic st, logic [31:0] edat, logic evld, logic emis, logic chkd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.ad = ad; v.wd = wd; v.st = st;
        v.edat = edat; v.evld = evld; v.emis = emis; v.chkd = chkd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int access_bytes(input logic wr, input logic [2:0] sz);
        if (wr) return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : (sz == 3'd2) ? 4 : 0;
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic model_edge(input logic rd, input logic wr, input logic [2:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd, input logic st);
        int a, n;
        logic [31:0] v;
        if (st) return;
        a = int'(ad % 4096);
        if (!rd && !wr) begin
            m_vld = 1'b0; m_mis = 1'b0;
            return;
        end
        n = access_bytes(wr, sz);
        if (n == 0 || (a % n) != 0) begin
            m_dat = 32'd0; m_vld = 1'b0; m_mis = 1'b1;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mem_b[a+k] = 8'((wd >> (8*k)) & 32'hFF);
            m_vld = 1'b0; m_mis = 1'b0;
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(mem_b[a+k]) << (8*k));
            if (sz == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            m_dat = v; m_vld = 1'b1; m_mis = 1'b0;
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd, input logic st);
        bus.MemRead_i   = rd;
        bus.MemWrite_i  = wr;
        bus.SizeCtrl_i  = sz;
        bus.Addr_i      = ad;
        bus.WriteData_i = wd;
        bus.Stall_i     = st;
        @(posedge clk);
        model_edge(rd, wr, sz, ad, wd, st);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"}, bus.ReadData_o, m_dat);
        chk({tag, "_vld"}, 32'(bus.LoadValid_o), 32'(m_vld));
        chk({tag, "_mis"}, 32'(bus.Misaligned_o), 32'(m_mis));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sz;
        bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0; bus.SizeCtrl_i = 3'd0;
        bus.Addr_i = '0; bus.WriteData_i = '0; bus.Stall_i = 1'b0;
        m_dat = 32'd0; m_vld = 1'b0; m_mis = 1'b0;

        #1;
        chk_model("reset_init");
        #20 rst_n = 1'b1;

        // Give every word a known value so the model and RAM agree.
        for (int i = 0; i < 1024; i++)
            step(1'b0, 1'b1, 3'd2, 32'(i*4), (32'(i) * 32'h0100_0193) ^ 32'h5A5A_5A5A, 1'b0);

        tbl.push_back(mk(0,1,3'd2,32'h100, 32'hDEADBEEF,0, 32'h0,        0,0,0));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'hDEADBEEF, 1,0,1));
        tbl.push_back(mk(1,0,3'd0,32'h103, 32'h0,       0, 32'hFFFFFFDE, 1,0,1));
        tbl.push_back(mk(1,0,3'd4,32'h103, 32'h0,       0, 32'h000000DE, 1,0,1));
        tbl.push_back(mk(1,0,3'd1,32'h100, 32'h0,       0, 32'hFFFFBEEF, 1,0,1));
        tbl.push_back(mk(1,0,3'd5,32'h102, 32'h0,       0, 32'h0000DEAD, 1,0,1));
        tbl.push_back(mk(0,1,3'd0,32'h101, 32'h12,      0, 32'h0,        0,0,0));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'hDEAD12EF, 1,0,1));
        tbl.push_back(mk(0,1,3'd1,32'h102, 32'h3456,    0, 32'h0,        0,0,0));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'h345612EF, 1,0,1));
        tbl.push_back(mk(1,0,3'd2,32'h102, 32'h0,       0, 32'h0,        0,1,1));
        tbl.push_back(mk(0,1,3'd1,32'h101, 32'hFFFF,    0, 32'h0,        0,1,1));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'h345612EF, 1,0,1));
        tbl.push_back(mk(0,1,3'd2,32'h100, 32'h11111111,1, 32'h345612EF, 1,0,1));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'h345612EF, 1,0,1));
        tbl.push_back(mk(0,1,3'd2,32'h1100,32'hCAFEF00D,0, 32'h0,        0,0,0));
        tbl.push_back(mk(1,0,3'd2,32'h100, 32'h0,       0, 32'hCAFEF00D, 1,0,1));
        tbl.push_back(mk(0,0,3'd0,32'h0,   32'h0,       0, 32'hCAFEF00D, 0,0,1));
        tbl.push_back(mk(1,0,3'd3,32'h100, 32'h0,       0, 32'h0,        0,1,1));
        tbl.push_back(mk(1,1,3'd2,32'h104, 32'h0BADF00D,0, 32'h0,        0,0,0));
        tbl.push_back(mk(1,0,3'd2,32'h104, 32'h0,       0, 32'h0BADF00D, 1,0,1));
        tbl.push_back(mk(0,1,3'd4,32'h104, 32'hFFFFFFFF,0, 32'h0,        0,1,1));
        tbl.push_back(mk(1,0,3'd2,32'h104, 32'h0,       0, 32'h0BADF00D, 1,0,1));

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].ad, tbl[i].wd, tbl[i].st);
            if (tbl[i].chkd) chk($sformatf("vec%0d_data", i), bus.ReadData_o, tbl[i].edat);
            chk($sformatf("vec%0d_vld", i), 32'(bus.LoadValid_o), 32'(tbl[i].evld));
            chk($sformatf("vec%0d_mis", i), 32'(bus.Misaligned_o), 32'(tbl[i].emis));
        end

        // Reset asserted mid-load clears outputs without a clock edge.
        bus.MemRead_i = 1'b1; bus.MemWrite_i = 1'b0; bus.SizeCtrl_i = 3'd2; bus.Addr_i = 32'h104;
        #1 rst_n = 1'b0;
        #1;
        m_dat = 32'd0; m_vld = 1'b0; m_mis = 1'b0;
        chk_model("async_reset");

        // A store held across clock edges during reset must not commit.
        bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b1; bus.Addr_i = 32'h100; bus.WriteData_i = 32'h55555555;
        @(posedge clk); @(posedge clk); #1;
        chk_model("in_reset");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        chk("post_reset_lw", bus.ReadData_o, 32'hCAFEF00D);
        chk_model("post_reset");

        for (int i = 0; i < 400; i++) begin
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) sz = ($urandom_range(0, 1) != 0) ? 3'd2 : sz;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), sz,
                 ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 7) == 0));
            chk_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
